// File: rtl/mips_pkg.sv
// Shared opcodes, ALU-op codes, mux selects, FSM state encoding and the
// control-word layout for the multicycle MIPS main controller.
package mips_pkg;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ORIEX   = 4'd10,
        ADDIWB  = 4'd11,
        JEX     = 4'd12,
        BNEEX   = 4'd13
    } state_t;

    typedef struct packed {
        logic       memreq;
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
        logic       pcen;
    } ctrl_t;

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Combinational state -> control-word decoder for the multicycle MIPS controller.
// MIPS_BNE_EN adds the BNEEX decode (branch when zero is clear).
module mips_ctrl_outdec
    import mips_pkg::*;
(
    input  state_t     state,
    input  logic       memready,
    input  logic       zero,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl         = '0;
        ctrl.alusrcb = SRCB_REG;
        ctrl.aluop   = ALUOP_ADD;
        ctrl.pcsrc   = PCSRC_ALU;
        case (state)
            FETCH: begin
                // IR and PC only load on the cycle memory actually returns the word
                ctrl.memreq  = 1'b1;
                ctrl.alusrcb = SRCB_FOUR;
                ctrl.irwrite = memready;
                ctrl.pcen    = memready;
            end
            DECODE: begin
                ctrl.alusrcb = SRCB_IMMSH;
            end
            MEMADR: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
            end
            MEMRD: begin
                ctrl.memreq = 1'b1;
                ctrl.iord   = 1'b1;
            end
            MEMWB: begin
                ctrl.memtoreg = 1'b1;
                ctrl.regwrite = 1'b1;
            end
            MEMWR: begin
                ctrl.memreq   = 1'b1;
                ctrl.iord     = 1'b1;
                ctrl.memwrite = memready;
            end
            RTYPEEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.aluop   = ALUOP_FUNCT;
            end
            RTYPEWB: begin
                ctrl.regdst   = 1'b1;
                ctrl.regwrite = 1'b1;
            end
            BEQEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.aluop   = ALUOP_SUB;
                ctrl.pcsrc   = PCSRC_ALUOUT;
                ctrl.pcen    = zero;
            end
`ifdef MIPS_BNE_EN
            BNEEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.aluop   = ALUOP_SUB;
                ctrl.pcsrc   = PCSRC_ALUOUT;
                ctrl.pcen    = ~zero;
            end
`endif
            ADDIEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
            end
            ORIEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
                ctrl.aluop   = ALUOP_OR;
            end
            ADDIWB: begin
                ctrl.regwrite = 1'b1;
            end
            JEX: begin
                ctrl.pcsrc = PCSRC_JUMP;
                ctrl.pcen  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_maincontroller.sv
// Multicycle MIPS main control FSM with memory-ready stalls.
// Define MIPS_BNE_EN to decode bne (op 000101); otherwise it is an illegal opcode.
module mips_maincontroller
    import mips_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         op,
    input  logic               zero,
    input  logic               memready,
    output logic               memreq,
    output logic               iord,
    output logic               memwrite,
    output logic               irwrite,
    output logic               regdst,
    output logic               memtoreg,
    output logic               regwrite,
    output logic               alusrca,
    output logic [1:0]         alusrcb,
    output logic [1:0]         aluop,
    output logic [1:0]         pcsrc,
    output logic               pcen,
    output logic               illegalop,
    output logic [STATE_W-1:0] state_o
);

    state_t state;
    state_t next_state;
    logic   illegal_dec;
    ctrl_t  ctrl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FETCH;
        else        state <= next_state;
    end

    always_comb begin
        next_state  = state;
        illegal_dec = 1'b0;
        case (state)
            FETCH:   if (memready) next_state = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_RTYPE:     next_state = RTYPEEX;
                    OP_BEQ:       next_state = BEQEX;
                    OP_ADDI:      next_state = ADDIEX;
                    OP_ORI:       next_state = ORIEX;
                    OP_J:         next_state = JEX;
`ifdef MIPS_BNE_EN
                    OP_BNE:       next_state = BNEEX;
`else
                    OP_BNE: begin
                        illegal_dec = 1'b1;
                        next_state  = FETCH;
                    end
`endif
                    default: begin
                        illegal_dec = 1'b1;
                        next_state  = FETCH;
                    end
                endcase
            end
            MEMADR:  next_state = (op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:   if (memready) next_state = MEMWB;
            MEMWR:   if (memready) next_state = FETCH;
            RTYPEEX: next_state = RTYPEWB;
            BEQEX:   next_state = FETCH;
            ADDIEX:  next_state = ADDIWB;
            ORIEX:   next_state = ADDIWB;
            default: next_state = FETCH;
        endcase
    end

    mips_ctrl_outdec u_outdec (
        .state    (state),
        .memready (memready),
        .zero     (zero),
        .ctrl     (ctrl)
    );

    // Strobes and requests are forced low while reset is asserted; selects keep FETCH values
    assign memreq    = ctrl.memreq   & rst_n;
    assign memwrite  = ctrl.memwrite & rst_n;
    assign irwrite   = ctrl.irwrite  & rst_n;
    assign regwrite  = ctrl.regwrite & rst_n;
    assign pcen      = ctrl.pcen     & rst_n;
    assign illegalop = illegal_dec   & rst_n;
    assign iord      = ctrl.iord;
    assign regdst    = ctrl.regdst;
    assign memtoreg  = ctrl.memtoreg;
    assign alusrca   = ctrl.alusrca;
    assign alusrcb   = ctrl.alusrcb;
    assign aluop     = ctrl.aluop;
    assign pcsrc     = ctrl.pcsrc;
    assign state_o   = STATE_W'(state);

endmodule

// File: tb/tb_mips_maincontroller.sv
// Scoreboard bench for mips_maincontroller: per-cycle expected control words
// are queued as stimulus is driven and compared at the following falling edge.
module tb_mips_maincontroller;
    import mips_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] op = 6'd0;
    logic       zero = 1'b0;
    logic       memready = 1'b1;
    logic       memreq, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, aluop, pcsrc;
    logic       pcen, illegalop;
    logic [3:0] state_o;

    mips_maincontroller #(.STATE_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .memready(memready),
        .memreq(memreq), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
        .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
        .alusrcb(alusrcb), .aluop(aluop), .pcsrc(pcsrc), .pcen(pcen),
        .illegalop(illegalop), .state_o(state_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic memreq, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
        logic [1:0] alusrcb, aluop, pcsrc;
        logic pcen, illegalop;
    } word_t;

    typedef struct {
        state_t     st;
        logic [5:0] op;
        logic       mr;
        logic       z;
        logic       ill;
    } step_t;

    word_t sb[$];
    step_t plan[$];
    int total = 0;
    int bad = 0;

    function automatic void add(state_t st, logic [5:0] o, logic mr, logic z, logic ill);
        step_t s;
        s.st = st; s.op = o; s.mr = mr; s.z = z; s.ill = ill;
        plan.push_back(s);
    endfunction

    // Expected outputs written straight from the state table, with raw bit values
    function automatic word_t model(state_t st, logic mr, logic z, logic ill, logic in_rst);
        word_t w = '0;
        w.st = st;
        case (st)
            FETCH:   begin w.memreq = 1; w.alusrcb = 2'b01; w.irwrite = mr; w.pcen = mr; end
            DECODE:  begin w.alusrcb = 2'b11; w.illegalop = ill; end
            MEMADR:  begin w.alusrca = 1; w.alusrcb = 2'b10; end
            MEMRD:   begin w.memreq = 1; w.iord = 1; end
            MEMWB:   begin w.memtoreg = 1; w.regwrite = 1; end
            MEMWR:   begin w.memreq = 1; w.iord = 1; w.memwrite = mr; end
            RTYPEEX: begin w.alusrca = 1; w.aluop = 2'b10; end
            RTYPEWB: begin w.regdst = 1; w.regwrite = 1; end
            BEQEX:   begin w.alusrca = 1; w.aluop = 2'b01; w.pcsrc = 2'b01; w.pcen = z; end
            BNEEX:   begin w.alusrca = 1; w.aluop = 2'b01; w.pcsrc = 2'b01; w.pcen = ~z; end
            ADDIEX:  begin w.alusrca = 1; w.alusrcb = 2'b10; end
            ORIEX:   begin w.alusrca = 1; w.alusrcb = 2'b10; w.aluop = 2'b11; end
            ADDIWB:  begin w.regwrite = 1; end
            JEX:     begin w.pcsrc = 2'b10; w.pcen = 1; end
            default: ;
        endcase
        if (in_rst) begin
            w.memreq = 0; w.irwrite = 0; w.pcen = 0; w.memwrite = 0;
            w.regwrite = 0; w.illegalop = 0;
        end
        return w;
    endfunction

    function automatic word_t observe();
        return {state_o, memreq, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
                alusrca, alusrcb, aluop, pcsrc, pcen, illegalop};
    endfunction

    task automatic test_reset();
        word_t e, o;
        memready = 1'b1;
        sb.push_back(model(FETCH, 1'b1, 1'b0, 1'b0, 1'b1));
        @(negedge clk);
        e = sb.pop_front(); o = observe(); total++;
        if (o !== e) begin bad++; $display("FAIL reset_initial: got %h need %h", o, e); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        plan.delete();
        add(FETCH, OP_LW, 1, 0, 0); add(DECODE, OP_LW, 1, 0, 0);
        add(MEMADR, OP_LW, 1, 0, 0); add(MEMRD, OP_LW, 0, 0, 0);
        foreach (plan[i]) begin
            op = plan[i].op; memready = plan[i].mr; zero = plan[i].z;
            sb.push_back(model(plan[i].st, plan[i].mr, plan[i].z, plan[i].ill, 1'b0));
            @(negedge clk);
            e = sb.pop_front(); o = observe(); total++;
            if (o !== e) begin bad++; $display("FAIL reset_pre step %0d: got %h need %h", i, o, e); end
            @(posedge clk); #1;
        end
        // Still stalled in MEMRD: assert reset with memready high, between edges
        memready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        sb.push_back(model(FETCH, 1'b1, 1'b0, 1'b0, 1'b1));
        e = sb.pop_front(); o = observe(); total++;
        if (o !== e) begin bad++; $display("FAIL reset_midmemrd: got %h need %h", o, e); end
        @(negedge clk); #2 rst_n = 1'b1;
        #1;
        sb.push_back(model(FETCH, 1'b1, 1'b0, 1'b0, 1'b0));
        e = sb.pop_front(); o = observe(); total++;
        if (o !== e) begin bad++; $display("FAIL reset_release: got %h need %h", o, e); end
        @(posedge clk); #1;
        sb.push_back(model(DECODE, 1'b1, 1'b0, 1'b0, 1'b0));
        e = sb.pop_front(); o = observe(); total++;
        if (o !== e) begin bad++; $display("FAIL reset_first_decode: got %h need %h", o, e); end
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
    endtask

    task automatic test_lw();
        word_t e, o;
        plan.delete();
        add(FETCH, OP_LW, 1, 0, 0); add(DECODE, OP_LW, 1, 0, 0); add(MEMADR, OP_LW, 1, 0, 0);
        add(MEMRD, OP_LW, 1, 0, 0); add(MEMWB, OP_LW, 1, 0, 0); add(FETCH, OP_LW, 0, 0, 0);
        foreach (plan[i]) begin
            op = plan[i].op; memready = plan[i].mr; zero = plan[i].z;
            sb.push_back(model(plan[i].st, plan[i].mr, plan[i].z, plan[i].ill, 1'b0));
            @(negedge clk);
            e = sb.pop_front(); o = observe(); total++;
            if (o !== e) begin bad++; $display("FAIL lw step %0d: got %h need %h", i, o, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sw_stall();
        word_t e, o;
        plan.delete();
        add(FETCH, OP_SW, 1, 0, 0); add(DECODE, OP_SW, 1, 0, 0); add(MEMADR, OP_SW, 1, 0, 0);
        add(MEMWR, OP_SW, 0, 0, 0); add(MEMWR, OP_SW, 0, 0, 0); add(MEMWR, OP_SW, 0, 0, 0);
        add(MEMWR, OP_SW, 1, 0, 0); add(FETCH, OP_SW, 0, 0, 0); add(FETCH, OP_SW, 0, 0, 0);
        foreach (plan[i]) begin
            op = plan[i].op; memready = plan[i].mr; zero = plan[i].z;
            sb.push_back(model(plan[i].st, plan[i].mr, plan[i].z, plan[i].ill, 1'b0));
            @(negedge clk);
            e = sb.pop_front(); o = observe(); total++;
            if (o !== e) begin bad++; $display("FAIL sw step %0d: got %h need %h", i, o, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_beq();
        word_t e, o;
        plan.delete();
        add(FETCH, OP_BEQ, 1, 1, 0); add(DECODE, OP_BEQ, 1, 1, 0); add(BEQEX, OP_BEQ, 1, 1, 0);
        add(FETCH, OP_BEQ, 1, 0, 0); add(DECODE, OP_BEQ, 1, 0, 0); add(BEQEX, OP_BEQ, 1, 0, 0);
        foreach (plan[i]) begin
            op = plan[i].op; memready = plan[i].mr; zero = plan[i].z;
            sb.push_back(model(plan[i].st, plan[i].mr, plan[i].z, plan[i].ill, 1'b0));
            @(negedge clk);
            e = sb.pop_front(); o = observe(); total++;
            if (o !== e) begin bad++; $display("FAIL beq step %0d: got %h need %h", i, o, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_ori();
        word_t e, o;
        plan.delete();
        add(FETCH, OP_ORI, 1, 0, 0); add(DECODE, OP_ORI, 1, 0, 0);
        add(ORIEX, OP_ORI, 1, 0, 0); add(ADDIWB, OP_ORI, 1, 0, 0);
        foreach (plan[i]) begin
            op = plan[i].op; memready = plan[i].mr; zero = plan[i].z;
            sb.push_back(model(plan[i].st, plan[i].mr, plan[i].z, plan[i].ill, 1'b0));
            @(negedge clk);
            e = sb.pop_front(); o = observe(); total++;
            if (o !== e) begin bad++; $display("FAIL ori step %0d: got %h need %h", i, o, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_bne();
        word_t e, o;
        plan.delete();
`ifdef MIPS_BNE_EN
        add(FETCH, OP_BNE, 1, 0, 0); add(DECODE, OP_BNE, 1, 0, 0); add(BNEEX, OP_BNE, 1, 0, 0);
        add(FETCH, OP_BNE, 1, 1, 0); add(DECODE, OP_BNE, 1, 1, 0); add(BNEEX, OP_BNE, 1, 1, 0);
`else
        add(FETCH, OP_BNE, 1, 0, 0); add(DECODE, OP_BNE, 1, 0, 1); add(FETCH, OP_BNE, 0, 0, 0);
`endif
        foreach (plan[i]) begin
            op = plan[i].op; memready = plan[i].mr; zero = plan[i].z;
            sb.push_back(model(plan[i].st, plan[i].mr, plan[i].z, plan[i].ill, 1'b0));
            @(negedge clk);
            e = sb.pop_front(); o = observe(); total++;
            if (o !== e) begin bad++; $display("FAIL bne step %0d: got %h need %h", i, o, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        word_t e, o;
        plan.delete();
        add(FETCH, OP_RTYPE, 1, 0, 0); add(DECODE, OP_RTYPE, 1, 0, 0);
        add(RTYPEEX, OP_RTYPE, 1, 0, 0); add(RTYPEWB, OP_RTYPE, 1, 0, 0);
        add(FETCH, OP_ADDI, 1, 0, 0); add(DECODE, OP_ADDI, 1, 0, 0);
        add(ADDIEX, OP_ADDI, 1, 0, 0); add(ADDIWB, OP_ADDI, 1, 0, 0);
        add(FETCH, OP_J, 1, 0, 0); add(DECODE, OP_J, 1, 0, 0); add(JEX, OP_J, 1, 0, 0);
        add(FETCH, 6'b111111, 1, 0, 0); add(DECODE, 6'b111111, 1, 0, 1);
        add(FETCH, OP_LW, 0, 0, 0); add(FETCH, OP_LW, 1, 0, 0);
        foreach (plan[i]) begin
            op = plan[i].op; memready = plan[i].mr; zero = plan[i].z;
            sb.push_back(model(plan[i].st, plan[i].mr, plan[i].z, plan[i].ill, 1'b0));
            @(negedge clk);
            e = sb.pop_front(); o = observe(); total++;
            if (o !== e) begin bad++; $display("FAIL b2b step %0d: got %h need %h", i, o, e); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw_stall();
        test_beq();
        test_ori();
        test_bne();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
